// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: decoder state encoding, 50 MHz line timing and pixel width.
// The transmitter uses the same timing constants.
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        IDLE      = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } ws_state_t;

    localparam int T0H     = 20;
    localparam int T1H     = 40;
    localparam int T0L     = 43;
    localparam int T1L     = 23;
    localparam int T_RESET = 2500;

    localparam int PIX_W   = 24;

endpackage

// File: rtl/ws2812_pulse_meter.sv
// Synchronizes the serial line, measures high/low widths and classifies each high pulse.
// state     | meaning
// SYNC_WAIT | waiting for a full latch-length low gap before trusting the line
// IDLE      | synchronized, line low, waiting for the first rising edge
// HIGH      | measuring a high pulse
// LOW       | measuring the low time after a bit
module ws2812_pulse_meter
    import ws2812_pkg::*;
#(
    parameter int THRESH_CYC   = 32,
    parameter int MIN_HIGH_CYC = 8,
    parameter int MAX_HIGH_CYC = 60,
    parameter int RESET_CYC    = T_RESET
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic bit_strobe,
    output logic bit_value,
    output logic glitch,
    output logic too_long,
    output logic latch
);

    localparam int CNT_MAX = ((RESET_CYC > MAX_HIGH_CYC) ? RESET_CYC : MAX_HIGH_CYC) + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] THR_C    = CNT_W'(THRESH_CYC);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH_CYC);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH_CYC);
    localparam logic [CNT_W-1:0] RST_C    = CNT_W'(RESET_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1, din_s, din_d;
    logic             rise, fall;
    ws_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            din_s <= 1'b0;
            din_d <= 1'b0;
            state <= SYNC_WAIT;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            din_s <= sync1;
            din_d <= din_s;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign rise    = din_s & ~din_d;
    assign fall    = ~din_s & din_d;
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    // cnt holds the number of samples seen at the current level, the edge cycle counting as one
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bit_strobe = 1'b0;
        bit_value  = 1'b0;
        glitch     = 1'b0;
        too_long   = 1'b0;
        latch      = 1'b0;
        case (state)
            SYNC_WAIT: begin
                if (din_s) begin
                    cnt_nxt = '0;
                end else if (cnt_inc >= RST_C) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_nxt = HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_nxt = LOW;
                    cnt_nxt   = CNT_ONE;
                    if (cnt < MIN_C) begin
                        glitch = 1'b1;
                    end else begin
                        bit_strobe = 1'b1;
                        bit_value  = (cnt >= THR_C);
                    end
                end else if (cnt >= MAX_C) begin
                    too_long  = 1'b1;
                    state_nxt = SYNC_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt = HIGH;
                    cnt_nxt   = CNT_ONE;
                end else if (cnt_inc >= RST_C) begin
                    latch     = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = SYNC_WAIT;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: assembles GRB pixel words from decoded bits and hands them out on valid/ready.
// Defining WS2812_RX_STATS_EN adds frame_count and err_count outputs.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int THRESH_CYC    = 32,
    parameter int MIN_HIGH_CYC  = 8,
    parameter int MAX_HIGH_CYC  = 60,
    parameter int RESET_CYC     = T_RESET,
    parameter int PIX_PER_FRAME = 64,
    parameter int IDX_W         = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [23:0]      pix_data,
    output logic [IDX_W-1:0] pix_index,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             frame_done,
    output logic             frame_short,
    output logic             bit_err,
    output logic             overflow
`ifdef WS2812_RX_STATS_EN
    ,
    output logic [15:0]      frame_count,
    output logic [7:0]       err_count
`endif
);

    // pix_seen saturates above PIX_PER_FRAME so the short-frame check survives index wrap
    localparam int SEEN_W = $clog2(PIX_PER_FRAME + 2);
    localparam logic [SEEN_W-1:0] SEEN_MAX  = SEEN_W'(PIX_PER_FRAME + 1);
    localparam logic [SEEN_W-1:0] SEEN_FULL = SEEN_W'(PIX_PER_FRAME);
    localparam logic [4:0]        BIT_LAST  = 5'(PIX_W - 1);

    logic              bit_strobe, bit_value, glitch, too_long, latch;
    logic [PIX_W-2:0]  word;
    logic [PIX_W-1:0]  word_nxt;
    logic [4:0]        bit_cnt;
    logic [IDX_W-1:0]  pix_cnt;
    logic [SEEN_W-1:0] pix_seen;
    logic              got_bit;
    logic              word_done, out_free;

    ws2812_pulse_meter #(
        .THRESH_CYC   (THRESH_CYC),
        .MIN_HIGH_CYC (MIN_HIGH_CYC),
        .MAX_HIGH_CYC (MAX_HIGH_CYC),
        .RESET_CYC    (RESET_CYC)
    ) u_meter (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .bit_strobe (bit_strobe),
        .bit_value  (bit_value),
        .glitch     (glitch),
        .too_long   (too_long),
        .latch      (latch)
    );

    assign word_nxt  = {word, bit_value};
    assign word_done = bit_strobe && (bit_cnt == BIT_LAST);
    assign out_free  = !pix_valid || pix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word        <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            pix_seen    <= '0;
            got_bit     <= 1'b0;
            pix_data    <= '0;
            pix_index   <= '0;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_short <= 1'b0;
            bit_err     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_short <= 1'b0;
            overflow    <= 1'b0;
            if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
            end
            if (bit_strobe) begin
                word    <= word_nxt[PIX_W-2:0];
                got_bit <= 1'b1;
                if (word_done) begin
                    bit_cnt <= '0;
                    pix_cnt <= pix_cnt + 1'b1;
                    if (pix_seen != SEEN_MAX) begin
                        pix_seen <= pix_seen + 1'b1;
                    end
                    if (out_free) begin
                        pix_data  <= word_nxt;
                        pix_index <= pix_cnt;
                        pix_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                        bit_err  <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (glitch) begin
                bit_err <= 1'b1;
            end
            if (too_long) begin
                bit_err <= 1'b1;
                bit_cnt <= '0;
            end
            if (latch) begin
                if (bit_cnt != '0) begin
                    bit_err <= 1'b1;
                end
                if (got_bit) begin
                    frame_done  <= 1'b1;
                    frame_short <= (pix_seen != SEEN_FULL);
                end
                pix_cnt  <= '0;
                pix_seen <= '0;
                bit_cnt  <= '0;
                got_bit  <= 1'b0;
            end
        end
    end

`ifdef WS2812_RX_STATS_EN
    logic err_event;
    assign err_event = glitch || too_long || (word_done && !out_free) ||
                       (latch && (bit_cnt != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (latch && got_bit) begin
                frame_count <= frame_count + 1'b1;
            end
            if (err_event && (err_count != 8'hFF)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives pulse trains, predicts pixels and frame ends from the
// transmitted words, and checks every accepted pixel and every frame_done against that prediction.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        pix_ready = 1'b0;
    logic [23:0] pix_data;
    logic [5:0]  pix_index;
    logic        pix_valid, frame_done, frame_short, bit_err, overflow;

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .pix_data    (pix_data),
        .pix_index   (pix_index),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .frame_done  (frame_done),
        .frame_short (frame_short),
        .bit_err     (bit_err),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    // model: expected pixels {index, data}, expected frame_short per frame end
    logic [29:0] exp_pix[$];
    logic        exp_short[$];
    int          m_idx = 0;
    int          m_cnt = 0;
    bit          m_got = 0;
    bit          m_sync = 0;
    bit          m_err = 0;

    // observation
    int          acc_count = 0, ovf_count = 0, fd_count = 0, valid_cycles = 0;
    logic [23:0] last_data = '0;
    logic [5:0]  last_idx = '0;
    logic        last_short = 1'b0;
    logic        prev_valid = 1'b0, prev_acc = 1'b0;
    logic [23:0] prev_data = '0;
    logic [5:0]  prev_idx = '0;
    logic [29:0] e;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_acc   = 1'b0;
            end else begin
                if (prev_valid && !prev_acc) begin
                    check("hold_valid", pix_valid, 1);
                    check("hold_data", {pix_index, pix_data}, {prev_idx, prev_data});
                end
                if (pix_valid) valid_cycles++;
                if (pix_valid && pix_ready) begin
                    acc_count++;
                    last_data = pix_data;
                    last_idx  = pix_index;
                    if (exp_pix.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_pix: got data 0x%06h idx %0d, required none",
                                 pix_data, pix_index);
                    end else begin
                        e = exp_pix.pop_front();
                        check("pix", {pix_index, pix_data}, e);
                    end
                end
                if (frame_done) begin
                    fd_count++;
                    last_short = frame_short;
                    if (exp_short.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_frame_done: got 1, required 0");
                    end else begin
                        check("frame_short", frame_short, exp_short.pop_front());
                    end
                end else if (frame_short) begin
                    n_checks++;
                    $display("FAIL frame_short_alone: got 1, required 0");
                end
                if (overflow) ovf_count++;
                prev_valid = pix_valid;
                prev_acc   = pix_valid && pix_ready;
                prev_data  = pix_data;
                prev_idx   = pix_index;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit slow);
        din = 1'b1;
        cyc(slow ? (b ? 40 : 20) : (b ? 34 : 10));
        din = 1'b0;
        cyc(slow ? (b ? 23 : 43) : 5);
    endtask

    task automatic send_bits(input logic [23:0] w, input int first, input int last, input bit slow);
        for (int i = first; i >= last; i--) send_bit(w[i], slow);
    endtask

    task automatic pixel(input logic [23:0] w, input bit keep, input bit slow);
        if (m_sync) begin
            if (keep) exp_pix.push_back({6'(m_idx), w});
            else m_err = 1;
            m_idx = (m_idx + 1) % 64;
            m_cnt++;
            m_got = 1;
        end
        send_bits(w, 23, 0, slow);
    endtask

    task automatic gap();
        din = 1'b0;
        if (m_sync) begin
            if (m_got) exp_short.push_back(m_cnt != 64);
            m_idx = 0;
            m_cnt = 0;
            m_got = 0;
        end
        m_sync = 1;
        cyc(2510);
    endtask

    task automatic model_reset();
        exp_pix.delete();
        m_idx = 0; m_cnt = 0; m_got = 0; m_sync = 0; m_err = 0;
    endtask

    int acc0;

    initial begin
        // reset values
        cyc(3);
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 0);
        check("rst_index", pix_index, 0);
        check("rst_flags", {frame_done, frame_short, bit_err, overflow}, 0);
        rst_n = 1'b1;
        gap();

        // nominal timing, alternating bits
        pix_ready = 1'b1;
        valid_cycles = 0;
        acc0 = acc_count;
        pixel(24'hAAAAAA, 1, 1);
        cyc(5);
        check("t1_data", last_data, 24'hAAAAAA);
        check("t1_index", last_idx, 0);
        check("t1_accepts", acc_count - acc0, 1);
        check("t1_valid_cycles", valid_cycles, 1);
        gap();
        check("t1_short", last_short, 1);

        // full frame
        acc0 = acc_count;
        for (int i = 0; i < 64; i++) pixel(24'h00FF00, 1, 0);
        check("t2_accepts", acc_count - acc0, 64);
        check("t2_last_index", last_idx, 63);
        gap();
        check("t2_frames", fd_count, 2);
        check("t2_short", last_short, 0);
        check("t2_bit_err", bit_err, 0);

        // short frame, next frame restarts at index 0
        for (int i = 0; i < 10; i++) pixel(24'h0000F0 + 24'(i), 1, 0);
        check("t3_last_index", last_idx, 9);
        gap();
        check("t3_short", last_short, 1);
        pixel(24'hC3C3C3, 1, 0);
        check("t3_restart_index", last_idx, 0);
        check("t3_restart_data", last_data, 24'hC3C3C3);
        gap();

        // glitch then over-long high: resync required
        check("t5_err_before", bit_err, 0);
        din = 1'b1; cyc(4);
        din = 1'b0; cyc(20);
        check("t5_err_glitch", bit_err, 1);
        din = 1'b1; cyc(100);
        din = 1'b0; cyc(5);
        m_err = 1;
        m_sync = 0;
        acc0 = acc_count;
        pixel(24'hFFFFFF, 1, 0);
        pixel(24'h00FF00, 1, 0);
        check("t5_no_pix", acc_count - acc0, 0);
        gap();
        pixel(24'h5A5A5A, 1, 0);
        check("t5_data", last_data, 24'h5A5A5A);
        check("t5_index", last_idx, 0);
        gap();
        check("t5_bit_err", bit_err, m_err);

        // asynchronous reset mid-pixel
        pix_ready = 1'b0;
        pixel(24'h777777, 1, 0);
        send_bits(24'h3C3C3C, 23, 12, 0);
        check("t6_pending", pix_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", pix_valid, 0);
        check("t6_rst_data", pix_data, 0);
        check("t6_rst_err", bit_err, 0);
        model_reset();
        cyc(3);
        rst_n = 1'b1;
        pix_ready = 1'b1;
        valid_cycles = 0;
        send_bits(24'h3C3C3C, 11, 0, 0);
        pixel(24'h111111, 1, 0);
        pixel(24'h222222, 1, 0);
        cyc(5);
        check("t6_no_lock", valid_cycles, 0);
        gap();

        // overflow while consumer stalls
        check("t4_err_before", bit_err, 0);
        pix_ready = 1'b0;
        pixel(24'h123456, 1, 0);
        pixel(24'hABCDEF, 0, 0);
        cyc(2);
        check("t4_valid", pix_valid, 1);
        check("t4_held_data", pix_data, 24'h123456);
        check("t4_held_index", pix_index, 0);
        check("t4_overflows", ovf_count, 1);
        check("t4_bit_err", bit_err, m_err);
        pix_ready = 1'b1;
        cyc(2);
        check("t4_accepted", last_data, 24'h123456);
        pixel(24'h0F0F0F, 1, 0);
        check("t4_next_index", last_idx, 2);
        gap();
        check("t4_short", last_short, 1);

        cyc(5);
        check("end_frames", fd_count, 6);
        check("end_pix_left", exp_pix.size(), 0);
        check("end_frames_left", exp_short.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
